// File: rtl/pipeline_hazard_unit.sv
// Hazard/back-channel control for a 5-stage pipeline: operand forwarding, load-use stall, memory-wait freeze
// with a sticky watchdog. Optional saturating stall counters are built when STALL_COUNT_EN is defined.
module pipeline_hazard_unit #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_dest,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_dest,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_dest,
  input  logic             wb_reg_write,
  input  logic             mem_busy,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             pc_le,
  output logic             if_id_le,
  output logic             id_ex_le,
  output logic             ex_mem_le,
  output logic             mem_wb_le,
  output logic             id_ex_bubble,
  output logic             mem_wb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] load_stall_count,
  output logic [CNT_W-1:0] mem_wait_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } wd_state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  wd_state_t  state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;

  // A stage supplies a source only when it writes a nonzero register that the ID instruction reads.
  function automatic logic hit(input logic [4:0] dest, input logic wr,
                               input logic [4:0] src, input logic used);
    return wr && used && (dest != 5'd0) && (dest == src);
  endfunction

  logic ex_a, mem_a, wb_a, ex_b, mem_b, wb_b;
  logic load_use, freeze;

  assign ex_a  = hit(ex_dest,  ex_reg_write,  id_rs, id_uses_rs);
  assign mem_a = hit(mem_dest, mem_reg_write, id_rs, id_uses_rs);
  assign wb_a  = hit(wb_dest,  wb_reg_write,  id_rs, id_uses_rs);
  assign ex_b  = hit(ex_dest,  ex_reg_write,  id_rt, id_uses_rt);
  assign mem_b = hit(mem_dest, mem_reg_write, id_rt, id_uses_rt);
  assign wb_b  = hit(wb_dest,  wb_reg_write,  id_rt, id_uses_rt);

  assign load_use = ex_mem_read && (ex_a || ex_b);
  assign freeze   = mem_busy || (state == TIMEOUT);

  // A load in EX has no data yet, so it is skipped and older stages may still forward.
  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (!reset) begin
      if (ex_a && !ex_mem_read) fwd_a_sel = 2'b01;
      else if (mem_a)           fwd_a_sel = 2'b10;
      else if (wb_a)            fwd_a_sel = 2'b11;
      if (ex_b && !ex_mem_read) fwd_b_sel = 2'b01;
      else if (mem_b)           fwd_b_sel = 2'b10;
      else if (wb_b)            fwd_b_sel = 2'b11;
    end
  end

  always_comb begin
    pc_le         = 1'b1;
    if_id_le      = 1'b1;
    id_ex_le      = 1'b1;
    ex_mem_le     = 1'b1;
    mem_wb_le     = 1'b1;
    id_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (reset) begin
      pc_le         = 1'b0;
      if_id_le      = 1'b0;
      id_ex_le      = 1'b0;
      ex_mem_le     = 1'b0;
      mem_wb_le     = 1'b0;
      id_ex_bubble  = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (freeze) begin
      pc_le     = 1'b0;
      if_id_le  = 1'b0;
      id_ex_le  = 1'b0;
      ex_mem_le = 1'b0;
      mem_wb_le = 1'b0;
    end else if (load_use) begin
      pc_le        = 1'b0;
      if_id_le     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (mem_busy) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (!mem_busy) begin
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
        end else if (wait_cnt == MAX_WAIT_C) begin
          state_nxt = TIMEOUT;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      TIMEOUT: state_nxt = TIMEOUT;
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  assign mem_timeout = (state == TIMEOUT);

`ifdef STALL_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_q, wait_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      wait_q  <= '0;
    end else begin
      if (load_use && !freeze && (stall_q != '1)) stall_q <= stall_q + CNT_ONE;
      if (mem_busy && (wait_q != '1))             wait_q  <= wait_q + CNT_ONE;
    end
  end

  assign load_stall_count = stall_q;
  assign mem_wait_count   = wait_q;
`else
  assign load_stall_count = '0;
  assign mem_wait_count   = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: directed hazard scenarios plus randomized traffic against a rule-level model.
module tb_pipeline_hazard_unit;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 32;
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_dest, mem_dest, wb_dest;
  logic id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write, mem_busy;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic pc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le, id_ex_bubble, mem_wb_bubble, mem_timeout;
  logic [CNT_W-1:0] load_stall_count, mem_wait_count;

  pipeline_hazard_unit #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_dest(mem_dest), .mem_reg_write(mem_reg_write),
    .wb_dest(wb_dest), .wb_reg_write(wb_reg_write), .mem_busy(mem_busy),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .pc_le(pc_le), .if_id_le(if_id_le), .id_ex_le(id_ex_le), .ex_mem_le(ex_mem_le), .mem_wb_le(mem_wb_le),
    .id_ex_bubble(id_ex_bubble), .mem_wb_bubble(mem_wb_bubble), .mem_timeout(mem_timeout),
    .load_stall_count(load_stall_count), .mem_wait_count(mem_wait_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: consecutive busy edges seen, sticky timeout, event counters.
  int     m_run;
  bit     m_timeout;
  longint m_stall, m_wait;

  logic [4:0] e_le;
  logic [1:0] e_bub, e_fa, e_fb;
  logic       e_to;
  longint     e_sc, e_wc;

  wire [4:0] le_vec  = {pc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le};
  wire [1:0] bub_vec = {id_ex_bubble, mem_wb_bubble};

  function automatic bit writes(input logic [4:0] dest, input logic wr, input logic [4:0] src);
    return (wr === 1'b1) && (dest != 0) && (dest == src);
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] src, input logic used);
    if (!used) return 2'd0;
    if (writes(ex_dest, ex_reg_write, src) && !ex_mem_read) return 2'd1;
    if (writes(mem_dest, mem_reg_write, src)) return 2'd2;
    if (writes(wb_dest, wb_reg_write, src)) return 2'd3;
    return 2'd0;
  endfunction

  function automatic bit ref_load_use();
    return ex_mem_read && ((id_uses_rs && writes(ex_dest, ex_reg_write, id_rs)) ||
                           (id_uses_rt && writes(ex_dest, ex_reg_write, id_rt)));
  endfunction

  function automatic void model_clear();
    m_run = 0; m_timeout = 0; m_stall = 0; m_wait = 0;
  endfunction

  function automatic void predict();
    bit lu, frz;
    lu  = ref_load_use();
    frz = mem_busy || m_timeout;
    if (reset) begin
      e_le = 5'b00000; e_bub = 2'b11; e_fa = 2'd0; e_fb = 2'd0;
    end else begin
      e_fa = ref_fwd(id_rs, id_uses_rs);
      e_fb = ref_fwd(id_rt, id_uses_rt);
      if (frz)     begin e_le = 5'b00000; e_bub = 2'b00; end
      else if (lu) begin e_le = 5'b00111; e_bub = 2'b10; end
      else         begin e_le = 5'b11111; e_bub = 2'b00; end
    end
    e_to = m_timeout;
`ifdef STALL_COUNT_EN
    e_sc = m_stall; e_wc = m_wait;
`else
    e_sc = 0; e_wc = 0;
`endif
  endfunction

  // Advance one clock; the model consumes the inputs that were stable across the edge.
  task automatic tick();
    bit lu, frz;
    @(posedge clk);
    if (reset) model_clear();
    else begin
      lu  = ref_load_use();
      frz = mem_busy || m_timeout;
      if (lu && !frz && m_stall < CNT_MAX) m_stall++;
      if (mem_busy && m_wait < CNT_MAX) m_wait++;
      if (!m_timeout) begin
        if (mem_busy) begin
          m_run++;
          if (m_run > MAX_WAIT) m_timeout = 1;
        end else m_run = 0;
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_dest = 0; ex_reg_write = 0; ex_mem_read = 0;
    mem_dest = 0; mem_reg_write = 0; wb_dest = 0; wb_reg_write = 0; mem_busy = 0;
  endtask

  task automatic set_load_use();
    clear_inputs();
    ex_dest = 8; ex_reg_write = 1; ex_mem_read = 1;
    id_rs = 8; id_rt = 10; id_uses_rs = 1; id_uses_rt = 1;
  endtask

  task automatic test_reset();
    reset = 1; model_clear();
    id_rs = 3; id_rt = 3; id_uses_rs = 1; id_uses_rt = 1;
    ex_dest = 3; ex_reg_write = 1; ex_mem_read = 0;
    mem_dest = 3; mem_reg_write = 1; wb_dest = 3; wb_reg_write = 1; mem_busy = 1;
    #3; predict();
    n_checks++; if (le_vec !== 5'b00000) begin n_fail++; $display("FAIL reset_le got %b exp 00000", le_vec); end
    n_checks++; if (bub_vec !== 2'b11) begin n_fail++; $display("FAIL reset_bub got %b exp 11", bub_vec); end
    n_checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL reset_fwd got %b/%b exp 00/00", fwd_a_sel, fwd_b_sel); end
    n_checks++; if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b exp 0", mem_timeout); end
    n_checks++; if (load_stall_count !== CNT_W'(e_sc) || mem_wait_count !== CNT_W'(e_wc)) begin n_fail++; $display("FAIL reset_counters got %0d/%0d exp 0/0", load_stall_count, mem_wait_count); end
    tick();
    reset = 0; clear_inputs();
    #1;
  endtask

  task automatic test_load_use();
    set_load_use(); #1; predict();
    n_checks++; if (le_vec !== 5'b00111) begin n_fail++; $display("FAIL lu_le got %b exp 00111", le_vec); end
    n_checks++; if (bub_vec !== 2'b10) begin n_fail++; $display("FAIL lu_bub got %b exp 10", bub_vec); end
    n_checks++; if (fwd_a_sel !== e_fa) begin n_fail++; $display("FAIL lu_fwd_a got %b exp %b", fwd_a_sel, e_fa); end
    tick();
    ex_dest = 0; ex_reg_write = 0; ex_mem_read = 0; mem_dest = 8; mem_reg_write = 1;
    #1; predict();
    n_checks++; if (fwd_a_sel !== 2'b10) begin n_fail++; $display("FAIL lu_next_fwd_a got %b exp 10", fwd_a_sel); end
    n_checks++; if (le_vec !== 5'b11111) begin n_fail++; $display("FAIL lu_next_le got %b exp 11111", le_vec); end
    n_checks++; if (load_stall_count !== CNT_W'(e_sc)) begin n_fail++; $display("FAIL lu_stall_count got %0d exp %0d", load_stall_count, e_sc); end
    tick();
  endtask

  task automatic test_priority();
    clear_inputs();
    ex_dest = 5; ex_reg_write = 1; mem_dest = 5; mem_reg_write = 1; wb_dest = 5; wb_reg_write = 1;
    id_rs = 5; id_uses_rs = 1; id_rt = 5; id_uses_rt = 0;
    #1;
    n_checks++; if (fwd_a_sel !== 2'b01) begin n_fail++; $display("FAIL prio_ex got %b exp 01", fwd_a_sel); end
    n_checks++; if (fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL prio_unused_b got %b exp 00", fwd_b_sel); end
    ex_reg_write = 0; #1;
    n_checks++; if (fwd_a_sel !== 2'b10) begin n_fail++; $display("FAIL prio_mem got %b exp 10", fwd_a_sel); end
    mem_reg_write = 0; #1;
    n_checks++; if (fwd_a_sel !== 2'b11) begin n_fail++; $display("FAIL prio_wb got %b exp 11", fwd_a_sel); end
    tick();
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    ex_reg_write = 1; ex_mem_read = 1; mem_reg_write = 1; wb_reg_write = 1;
    id_rt = 0; id_uses_rt = 1; id_rs = 0; id_uses_rs = 1;
    #1;
    n_checks++; if (fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL zero_fwd_b got %b exp 00", fwd_b_sel); end
    n_checks++; if (le_vec !== 5'b11111 || bub_vec !== 2'b00) begin n_fail++; $display("FAIL zero_nostall got %b/%b exp 11111/00", le_vec, bub_vec); end
    tick();
  endtask

  task automatic test_watchdog();
    clear_inputs(); mem_busy = 1;
    for (int i = 0; i < MAX_WAIT; i++) begin
      #1;
      n_checks++; if (le_vec !== 5'b00000 || bub_vec !== 2'b00) begin n_fail++; $display("FAIL wd_freeze cyc %0d got %b/%b exp 00000/00", i, le_vec, bub_vec); end
      tick();
    end
    mem_busy = 0; #1;
    n_checks++; if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_no_timeout got %b exp 0", mem_timeout); end
    n_checks++; if (le_vec !== 5'b11111) begin n_fail++; $display("FAIL wd_run_after got %b exp 11111", le_vec); end
    tick();
    mem_busy = 1;
    for (int i = 0; i <= MAX_WAIT; i++) tick();
    mem_busy = 0; #1;
    n_checks++; if (mem_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_timeout got %b exp 1", mem_timeout); end
    n_checks++; if (le_vec !== 5'b00000) begin n_fail++; $display("FAIL wd_halt got %b exp 00000", le_vec); end
    tick(); tick();
    n_checks++; if (le_vec !== 5'b00000 || mem_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_sticky got %b/%b exp 00000/1", le_vec, mem_timeout); end
    #2; reset = 1; model_clear(); #1;
    n_checks++; if (mem_timeout !== 1'b0 || le_vec !== 5'b00000 || bub_vec !== 2'b11) begin n_fail++; $display("FAIL wd_reset got %b/%b/%b exp 0/00000/11", mem_timeout, le_vec, bub_vec); end
    tick(); reset = 0; #1;
    n_checks++; if (le_vec !== 5'b11111) begin n_fail++; $display("FAIL wd_after_reset got %b exp 11111", le_vec); end
    tick();
  endtask

  task automatic test_busy_load_use();
    set_load_use(); mem_busy = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (le_vec !== 5'b00000 || bub_vec !== 2'b00) begin n_fail++; $display("FAIL blu_freeze got %b/%b exp 00000/00", le_vec, bub_vec); end
      tick();
    end
    mem_busy = 0; #1;
    n_checks++; if (le_vec !== 5'b00111 || bub_vec !== 2'b10) begin n_fail++; $display("FAIL blu_stall got %b/%b exp 00111/10", le_vec, bub_vec); end
    tick();
    ex_dest = 0; ex_reg_write = 0; ex_mem_read = 0; mem_dest = 8; mem_reg_write = 1; #1; predict();
    n_checks++; if (le_vec !== 5'b11111 || fwd_a_sel !== 2'b10) begin n_fail++; $display("FAIL blu_after got %b/%b exp 11111/10", le_vec, fwd_a_sel); end
    n_checks++; if (mem_wait_count !== CNT_W'(e_wc) || load_stall_count !== CNT_W'(e_sc)) begin n_fail++; $display("FAIL blu_counts got %0d/%0d exp %0d/%0d", mem_wait_count, load_stall_count, e_wc, e_sc); end
    tick();
  endtask

  task automatic test_reset_in_stall();
    set_load_use(); #1;
    n_checks++; if (le_vec !== 5'b00111) begin n_fail++; $display("FAIL ris_stall got %b exp 00111", le_vec); end
    #2; reset = 1; model_clear(); #1; predict();
    n_checks++; if (le_vec !== e_le || bub_vec !== e_bub) begin n_fail++; $display("FAIL ris_ctrl got %b/%b exp %b/%b", le_vec, bub_vec, e_le, e_bub); end
    n_checks++; if (fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL ris_fwd got %b exp 00", fwd_a_sel); end
    n_checks++; if (load_stall_count !== 0 || mem_wait_count !== 0) begin n_fail++; $display("FAIL ris_counters got %0d/%0d exp 0/0", load_stall_count, mem_wait_count); end
    tick(); reset = 0; clear_inputs(); #1;
    tick();
  endtask

  task automatic test_random();
    int busy_left = 0;
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 99) == 0) || (m_timeout && $urandom_range(0, 5) == 0);
      if (reset) model_clear();
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
      ex_dest = 5'($urandom_range(0, 3)); ex_reg_write = 1'($urandom); ex_mem_read = 1'($urandom);
      mem_dest = 5'($urandom_range(0, 3)); mem_reg_write = 1'($urandom);
      wb_dest = 5'($urandom_range(0, 3)); wb_reg_write = 1'($urandom);
      if (busy_left == 0 && $urandom_range(0, 9) == 0) busy_left = $urandom_range(1, 7);
      mem_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      #1; predict();
      n_checks++; if (fwd_a_sel !== e_fa) begin n_fail++; $display("FAIL rnd_fwd_a c%0d got %b exp %b", c, fwd_a_sel, e_fa); end
      n_checks++; if (fwd_b_sel !== e_fb) begin n_fail++; $display("FAIL rnd_fwd_b c%0d got %b exp %b", c, fwd_b_sel, e_fb); end
      n_checks++; if (le_vec !== e_le) begin n_fail++; $display("FAIL rnd_le c%0d got %b exp %b", c, le_vec, e_le); end
      n_checks++; if (bub_vec !== e_bub) begin n_fail++; $display("FAIL rnd_bub c%0d got %b exp %b", c, bub_vec, e_bub); end
      n_checks++; if (mem_timeout !== e_to) begin n_fail++; $display("FAIL rnd_timeout c%0d got %b exp %b", c, mem_timeout, e_to); end
      n_checks++; if (load_stall_count !== CNT_W'(e_sc)) begin n_fail++; $display("FAIL rnd_stall_cnt c%0d got %0d exp %0d", c, load_stall_count, e_sc); end
      n_checks++; if (mem_wait_count !== CNT_W'(e_wc)) begin n_fail++; $display("FAIL rnd_wait_cnt c%0d got %0d exp %0d", c, mem_wait_count, e_wc); end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_priority();
    test_zero_reg();
    test_watchdog();
    test_busy_load_use();
    test_reset_in_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
